// File: rtl/vga_pkg.sv
// Shared timing constants and types for the VGA raster generator.
// Holds 800x600@72 defaults, a 640x480@60 set and the counter width.
package vga_pkg;

  localparam int COORD_W = 32'd11;

  // 800x600@72, 50 MHz pixel clock
  localparam int SVGA_H_SYNC      = 32'd120;
  localparam int SVGA_H_BACK      = 32'd64;
  localparam int SVGA_H_ACTIVE    = 32'd800;
  localparam int SVGA_H_FRONT     = 32'd56;
  localparam int SVGA_V_SYNC      = 32'd6;
  localparam int SVGA_V_BACK      = 32'd23;
  localparam int SVGA_V_ACTIVE    = 32'd600;
  localparam int SVGA_V_FRONT     = 32'd37;
  localparam int SVGA_H_TOTAL     = SVGA_H_SYNC + SVGA_H_BACK + SVGA_H_ACTIVE + SVGA_H_FRONT;
  localparam int SVGA_V_TOTAL     = SVGA_V_SYNC + SVGA_V_BACK + SVGA_V_ACTIVE + SVGA_V_FRONT;
  localparam int SVGA_H_ACT_START = SVGA_H_SYNC + SVGA_H_BACK;
  localparam int SVGA_V_ACT_START = SVGA_V_SYNC + SVGA_V_BACK;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA_H_SYNC       = 32'd96;
  localparam int VGA_H_BACK       = 32'd48;
  localparam int VGA_H_ACTIVE     = 32'd640;
  localparam int VGA_H_FRONT      = 32'd16;
  localparam int VGA_V_SYNC       = 32'd2;
  localparam int VGA_V_BACK       = 32'd33;
  localparam int VGA_V_ACTIVE     = 32'd480;
  localparam int VGA_V_FRONT      = 32'd10;
  localparam int VGA_H_TOTAL      = VGA_H_SYNC + VGA_H_BACK + VGA_H_ACTIVE + VGA_H_FRONT;
  localparam int VGA_V_TOTAL      = VGA_V_SYNC + VGA_V_BACK + VGA_V_ACTIVE + VGA_V_FRONT;
  localparam int VGA_H_ACT_START  = VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_ACT_START  = VGA_V_SYNC + VGA_V_BACK;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_bus_t;

  function automatic logic fits_coord(input int total);
    return (total >= 32'sd1) && (total <= (32'sd1 <<< COORD_W));
  endfunction

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// Fixed-depth shift register advanced only on pixel ticks; reset fills
// every stage with RST_VAL so no stale state reaches the outputs.
module vga_delay_line #(
  parameter int               WIDTH   = 32'd3,
  parameter int               DEPTH   = 32'd3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift on ce, flush to the fill value on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= RST_VAL;
    end else if (ce) begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: raw counters, registered active-area decode,
// line/frame strobes, and sync/de delayed to match the rgb pipeline.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_SYNC     = SVGA_H_SYNC,
  parameter int   H_BACK     = SVGA_H_BACK,
  parameter int   H_ACTIVE   = SVGA_H_ACTIVE,
  parameter int   H_FRONT    = SVGA_H_FRONT,
  parameter int   V_SYNC     = SVGA_V_SYNC,
  parameter int   V_BACK     = SVGA_V_BACK,
  parameter int   V_ACTIVE   = SVGA_V_ACTIVE,
  parameter int   V_FRONT    = SVGA_V_FRONT,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   PIPE_DELAY = 32'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic [10:0] c1,
  output logic [10:0] c2,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        de,
  output logic        frame_start,
  output logic        line_start,
  output logic        hsync,
  output logic        vsync,
  output logic        de_d
);

  localparam int H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int V_ACT_START = V_SYNC + V_BACK;

  // 12-bit compare constants so an end-of-window of 2048 still fits
  localparam logic [11:0] H_LAST_C  = 12'(H_TOTAL - 32'sd1);
  localparam logic [11:0] V_LAST_C  = 12'(V_TOTAL - 32'sd1);
  localparam logic [11:0] H_SYNC_C  = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_C  = 12'(V_SYNC);
  localparam logic [11:0] H_BEG_C   = 12'(H_ACT_START);
  localparam logic [11:0] V_BEG_C   = 12'(V_ACT_START);
  localparam logic [11:0] H_END_C   = 12'(H_ACT_START + H_ACTIVE);
  localparam logic [11:0] V_END_C   = 12'(V_ACT_START + V_ACTIVE);
  localparam logic [10:0] H_OFF_C   = 11'(H_ACT_START);
  localparam logic [10:0] V_OFF_C   = 11'(V_ACT_START);
  localparam logic [2:0]  DLY_FILL  = {~SYNC_POL, ~SYNC_POL, 1'b0};

  if (!fits_coord(H_TOTAL) || !fits_coord(V_TOTAL)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be 1..2048");
  end
  if ((PIPE_DELAY < 32'sd1) || (PIPE_DELAY > 32'sd15)) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be 1..15");
  end

  logic [10:0] c1_r, c2_r, x_r, y_r;
  logic [10:0] c1_nxt_s, c2_nxt_s, x_nxt_s, y_nxt_s;
  logic        de_r, h_act_r, v_act_r, frame_start_r, line_start_r;
  logic        de_nxt_s, h_act_nxt_s, v_act_nxt_s;
  sync_bus_t   dly_in_s, dly_out_s;

  // Next raster position
  always_comb begin
    c1_nxt_s = c1_r;
    c2_nxt_s = c2_r;
    if ({1'b0, c1_r} == H_LAST_C) begin
      c1_nxt_s = 11'd0;
      if ({1'b0, c2_r} == V_LAST_C) begin
        c2_nxt_s = 11'd0;
      end else begin
        c2_nxt_s = c2_r + 11'd1;
      end
    end else begin
      c1_nxt_s = c1_r + 11'd1;
    end
  end

  // Decode the next position so flags register alongside the counters
  always_comb begin
    h_act_nxt_s = ({1'b0, c1_nxt_s} < H_SYNC_C);
    v_act_nxt_s = ({1'b0, c2_nxt_s} < V_SYNC_C);
    de_nxt_s    = ({1'b0, c1_nxt_s} >= H_BEG_C) && ({1'b0, c1_nxt_s} < H_END_C) &&
                  ({1'b0, c2_nxt_s} >= V_BEG_C) && ({1'b0, c2_nxt_s} < V_END_C);
    x_nxt_s     = 11'd0;
    y_nxt_s     = 11'd0;
    if (de_nxt_s) begin
      x_nxt_s = c1_nxt_s - H_OFF_C;
      y_nxt_s = c2_nxt_s - V_OFF_C;
    end else begin
      x_nxt_s = 11'd0;
      y_nxt_s = 11'd0;
    end
  end

  // Counter, decode and strobe registers; raw sync flags reset to the decode of (0,0)
  always_ff @(posedge clk) begin
    if (rst) begin
      c1_r          <= 11'd0;
      c2_r          <= 11'd0;
      x_r           <= 11'd0;
      y_r           <= 11'd0;
      de_r          <= 1'b0;
      h_act_r       <= (12'd0 < H_SYNC_C);
      v_act_r       <= (12'd0 < V_SYNC_C);
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (ce) begin
      c1_r          <= c1_nxt_s;
      c2_r          <= c2_nxt_s;
      x_r           <= x_nxt_s;
      y_r           <= y_nxt_s;
      de_r          <= de_nxt_s;
      h_act_r       <= h_act_nxt_s;
      v_act_r       <= v_act_nxt_s;
      line_start_r  <= (c1_nxt_s == 11'd0);
      frame_start_r <= (c1_nxt_s == 11'd0) && (c2_nxt_s == 11'd0);
    end else begin
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end
  end

  // Sync levels enter the delay line already polarised so outputs come straight from flops
  always_comb begin
    dly_in_s.hsync = h_act_r ? SYNC_POL : ~SYNC_POL;
    dly_in_s.vsync = v_act_r ? SYNC_POL : ~SYNC_POL;
    dly_in_s.de    = de_r;
  end

  vga_delay_line #(
    .WIDTH   (32'd3),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (DLY_FILL)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .din  (dly_in_s),
    .dout (dly_out_s)
  );

  assign c1          = c1_r;
  assign c2          = c2_r;
  assign x           = x_r;
  assign y           = y_r;
  assign de          = de_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign hsync       = dly_out_s.hsync;
  assign vsync       = dly_out_s.vsync;
  assign de_d        = dly_out_s.de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x600 instance checked cycle-by-cycle against a
// tick-count model, plus a tiny-raster instance with SYNC_POL=1, PIPE_DELAY=1.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] c1, c2, x, y;
    logic        de, fs, ls, hs, vs, ded;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, ce_a, rst_b, ce_b;
  logic [10:0] a_c1, a_c2, a_x, a_y, b_c1, b_c2, b_x, b_y;
  logic a_de, a_fs, a_ls, a_hs, a_vs, a_ded;
  logic b_de, b_fs, b_ls, b_hs, b_vs, b_ded;

  int total = 0;
  int bad   = 0;
  int n_a, n_b;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .ce(ce_a),
    .c1(a_c1), .c2(a_c2), .x(a_x), .y(a_y), .de(a_de),
    .frame_start(a_fs), .line_start(a_ls),
    .hsync(a_hs), .vsync(a_vs), .de_d(a_ded)
  );

  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(1), .V_ACTIVE(5), .V_FRONT(2),
    .SYNC_POL(1'b1), .PIPE_DELAY(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .ce(ce_b),
    .c1(b_c1), .c2(b_c2), .x(b_x), .y(b_y), .de(b_de),
    .frame_start(b_fs), .line_start(b_ls),
    .hsync(b_hs), .vsync(b_vs), .de_d(b_ded)
  );

  // Expected outputs after n pixel ticks since reset release
  function automatic exp_t model(input int n, input logic ce_v,
                                 input int hs, input int hb, input int ha, input int hf,
                                 input int vs, input int vb, input int va, input int vf,
                                 input logic pol, input int pd);
    exp_t e;
    int ht, vt, c1, c2, m, mc1, mc2;
    logic act, mact;
    ht  = hs + hb + ha + hf;
    vt  = vs + vb + va + vf;
    c1  = n % ht;
    c2  = (n / ht) % vt;
    act = (c1 >= hs + hb) && (c1 < hs + hb + ha) && (c2 >= vs + vb) && (c2 < vs + vb + va);
    e.c1 = 11'(c1);
    e.c2 = 11'(c2);
    e.de = act;
    e.x  = act ? 11'(c1 - hs - hb) : 11'd0;
    e.y  = act ? 11'(c2 - vs - vb) : 11'd0;
    e.ls = ce_v && (n > 0) && (c1 == 0);
    e.fs = e.ls && (c2 == 0);
    m = n - pd;
    if (m < 0) begin
      e.hs  = ~pol;
      e.vs  = ~pol;
      e.ded = 1'b0;
    end else begin
      mc1  = m % ht;
      mc2  = (m / ht) % vt;
      mact = (mc1 >= hs + hb) && (mc1 < hs + hb + ha) && (mc2 >= vs + vb) && (mc2 < vs + vb + va);
      e.hs  = (mc1 < hs) ? pol : ~pol;
      e.vs  = (mc2 < vs) ? pol : ~pol;
      e.ded = mact;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_a(input logic ce_v);
    exp_t e;
    ce_a = ce_v;
    tick();
    if (ce_v) n_a++;
    e = model(n_a, ce_v, 120, 64, 800, 56, 6, 23, 600, 37, 1'b0, 3);
    chk("a.c1", int'(a_c1), int'(e.c1));
    chk("a.c2", int'(a_c2), int'(e.c2));
    chk("a.x", int'(a_x), int'(e.x));
    chk("a.y", int'(a_y), int'(e.y));
    chk("a.de", int'(a_de), int'(e.de));
    chk("a.line_start", int'(a_ls), int'(e.ls));
    chk("a.frame_start", int'(a_fs), int'(e.fs));
    chk("a.hsync", int'(a_hs), int'(e.hs));
    chk("a.vsync", int'(a_vs), int'(e.vs));
    chk("a.de_d", int'(a_ded), int'(e.ded));
  endtask

  task automatic step_b(input logic ce_v);
    exp_t e;
    ce_b = ce_v;
    tick();
    if (ce_v) n_b++;
    e = model(n_b, ce_v, 4, 3, 10, 2, 2, 1, 5, 2, 1'b1, 1);
    chk("b.c1", int'(b_c1), int'(e.c1));
    chk("b.c2", int'(b_c2), int'(e.c2));
    chk("b.x", int'(b_x), int'(e.x));
    chk("b.y", int'(b_y), int'(e.y));
    chk("b.de", int'(b_de), int'(e.de));
    chk("b.line_start", int'(b_ls), int'(e.ls));
    chk("b.frame_start", int'(b_fs), int'(e.fs));
    chk("b.hsync", int'(b_hs), int'(e.hs));
    chk("b.vsync", int'(b_vs), int'(e.vs));
    chk("b.de_d", int'(b_ded), int'(e.ded));
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".c1"}, int'(a_c1), 0);
    chk({tag, ".c2"}, int'(a_c2), 0);
    chk({tag, ".x"}, int'(a_x), 0);
    chk({tag, ".y"}, int'(a_y), 0);
    chk({tag, ".de"}, int'(a_de), 0);
    chk({tag, ".de_d"}, int'(a_ded), 0);
    chk({tag, ".frame_start"}, int'(a_fs), 0);
    chk({tag, ".line_start"}, int'(a_ls), 0);
    chk({tag, ".hsync"}, int'(a_hs), 1);
    chk({tag, ".vsync"}, int'(a_vs), 1);
  endtask

  initial begin
    int hs_low, first_low, ls_cnt, de_cnt, fs_cnt, hs_hi, vs_hi, de_b, max_y;

    rst_a = 1'b1; ce_a = 1'b1; rst_b = 1'b1; ce_b = 1'b1;
    tick();
    tick();
    chk_reset_a("a.reset");
    chk("b.reset.hsync", int'(b_hs), 0);
    chk("b.reset.vsync", int'(b_vs), 0);
    chk("b.reset.de_d", int'(b_ded), 0);

    // First line plus the wrap into line 1
    rst_a = 1'b0;
    n_a = 0;
    hs_low = 0; first_low = -1; ls_cnt = 0;
    for (int i = 0; i < 1040; i++) begin
      step_a(1'b1);
      if (a_ls) ls_cnt++;
      if (n_a < 1040 && a_hs == 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = n_a;
      end
    end
    chk("a.hsync_low_clks", hs_low, 120);
    chk("a.hsync_first_low", first_low, 3);
    chk("a.line_start_count", ls_cnt, 1);
    chk("a.wrap_c1", int'(a_c1), 0);
    chk("a.wrap_c2", int'(a_c2), 1);

    // ce pattern 1,0,0,1: everything holds and strobes stay low on idle clks
    for (int i = 0; i < 60; i++) begin
      step_a(1'b1);
      step_a(1'b0);
      step_a(1'b0);
      step_a(1'b1);
    end

    // Run to line 29 and measure the active window there
    while (n_a < 29 * 1040) step_a(1'b1);
    de_cnt = 0;
    for (int i = 0; i < 1040; i++) begin
      step_a(1'b1);
      if (a_c2 == 11'd29 && a_de) de_cnt++;
      if (a_c2 == 11'd29 && a_c1 == 11'd184) chk("a.x_first", int'(a_x), 0);
      if (a_c2 == 11'd29 && a_c1 == 11'd983) chk("a.x_last", int'(a_x), 799);
    end
    chk("a.de_clks_line29", de_cnt, 800);

    // Mid-frame reset with de_d high in the delay line
    for (int i = 0; i < 500; i++) step_a(1'b1);
    chk("a.pre_rst_c1", int'(a_c1), 500);
    chk("a.pre_rst_de_d", int'(a_ded), 1);
    rst_a = 1'b1;
    ce_a  = 1'b1;
    tick();
    chk_reset_a("a.midreset");
    rst_a = 1'b0;
    n_a = 0;
    for (int i = 0; i < 200; i++) step_a(1'b1);

    // Small raster, SYNC_POL=1, PIPE_DELAY=1, with occasional idle clks
    ce_a  = 1'b0;
    rst_b = 1'b0;
    n_b = 0;
    fs_cnt = 0; hs_hi = 0; vs_hi = 0; de_b = 0; max_y = 0;
    for (int i = 0; i < 385; i++) begin
      if (i % 7 == 3) step_b(1'b0);
      step_b(1'b1);
      if (b_fs) fs_cnt++;
      if (n_b <= 19 && b_hs) hs_hi++;
      if (n_b <= 190 && b_vs) vs_hi++;
      if (n_b <= 190 && b_de) de_b++;
      if (b_de && int'(b_y) > max_y) max_y = int'(b_y);
    end
    chk("b.frame_start_count", fs_cnt, 2);
    chk("b.hsync_high_clks", hs_hi, 4);
    chk("b.vsync_high_clks", vs_hi, 38);
    chk("b.de_clks_frame", de_b, 50);
    chk("b.y_max", max_y, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
